ps2_keypad: RTL and testbench

PS/2 keyboard receiver and CHIP-8 keypad decoder. Consumes the device-side PS/2 stream that `user_io` drives from the host keyboard, at roughly 12 kHz. Recovers Set-2 scan-code bytes, folds the E0/F0 prefixes into single key events, and maintains the 16-key CHIP-8 held-key bitmap. Sits in the `clk_25M` domain between `user_io` and the chip8 machine's key inputs.

---
 rtl/ps2_keypad_pkg.sv | 59 +++++
 rtl/ps2_keypad_frame_rx.sv | 161 ++++++++++++++++
 rtl/ps2_keypad.sv | 109 ++++++++++
 tb/tb_ps2_keypad.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keypad_pkg
// Description : Shared definitions for the PS/2 keypad receiver.
//               - Frame FSM state encoding
//               - Set-2 prefix bytes (extended, break)
//               - chip8_keymap: Set-2 code -> {valid, CHIP-8 key index}
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_keypad_pkg;

    // Frame receiver states.
    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_DATA   = 2'd1,
        c_ST_PARITY = 2'd2,
        c_ST_STOP   = 2'd3
    } rx_state_t;

    // Set-2 prefix bytes.
    localparam logic [7:0] c_PS2_EXT = 8'hE0;
    localparam logic [7:0] c_PS2_BRK = 8'hF0;

    // Keymap lookup result.
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } keymap_t;

    // Keyboard layout 1234/QWER/ASDF/ZXCV onto the CHIP-8 hex pad
    // 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F.
    function automatic keymap_t chip8_keymap(input logic [7:0] code);
        keymap_t m;
        m.valid = 1'b1;
        m.idx   = 4'h0;
        case (code)
            8'h22:   m.idx = 4'h0;  // X
            8'h16:   m.idx = 4'h1;  // 1
            8'h1E:   m.idx = 4'h2;  // 2
            8'h26:   m.idx = 4'h3;  // 3
            8'h15:   m.idx = 4'h4;  // Q
            8'h1D:   m.idx = 4'h5;  // W
            8'h24:   m.idx = 4'h6;  // E
            8'h1C:   m.idx = 4'h7;  // A
            8'h1B:   m.idx = 4'h8;  // S
            8'h23:   m.idx = 4'h9;  // D
            8'h1A:   m.idx = 4'hA;  // Z
            8'h21:   m.idx = 4'hB;  // C
            8'h25:   m.idx = 4'hC;  // 4
            8'h2D:   m.idx = 4'hD;  // R
            8'h2B:   m.idx = 4'hE;  // F
            8'h2A:   m.idx = 4'hF;  // V
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keypad_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 device-to-host frame receiver. Synchronises the PS/2
//               clock and data, detects ps2_clk falling edges, collects the
//               11-bit frame (start, 8 data LSB first, odd parity, stop) and
//               aborts a stalled frame after TIMEOUT_CYC idle cycles.
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               i_ps2_clk    - PS/2 clock (asynchronous, idles high)
//               i_ps2_data   - PS/2 data (asynchronous, idles high)
//               o_byte       - received byte (valid with o_byte_valid)
//               o_byte_valid - one-cycle strobe, good frame received
//               o_frame_err  - one-cycle strobe, parity/stop/timeout error
//               o_timeout    - one-cycle strobe, frame aborted by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_timeout
);

    localparam int              CNT_W          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Synchronisers idle high so reset does not fake a falling edge.
    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_d;
    // Registered edge detect; data captured alongside so the pair is coherent.
    logic r_fall, r_dat;

    rx_state_t        r_state, w_state_next;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic w_byte_valid, w_frame_err, w_timeout, w_parity_ok, w_fall_raw;

    assign w_fall_raw = r_clk_d & ~r_clk_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_fall   <= 1'b0;
            r_dat    <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_clk_d  <= r_clk_s2;
            r_fall   <= w_fall_raw;
            r_dat    <= r_dat_s2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and strobes. A fall always wins over the timeout, since the
    // fall itself restarts the idle count.
    always_comb begin
        w_state_next = r_state;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        w_timeout    = 1'b0;
        w_parity_ok  = ^{r_shift, r_par};
        if (r_fall) begin
            case (r_state)
                c_ST_IDLE: begin
                    // A high "start bit" is a glitch: ignore silently.
                    if (!r_dat) begin
                        w_state_next = c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = c_ST_PARITY;
                    end
                end
                c_ST_PARITY: begin
                    w_state_next = c_ST_STOP;
                end
                c_ST_STOP: begin
                    w_state_next = c_ST_IDLE;
                    if (r_dat && w_parity_ok) begin
                        w_byte_valid = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end else if ((r_state != c_ST_IDLE) && (r_tmo_cnt == c_TIMEOUT_LAST)) begin
            w_state_next = c_ST_IDLE;
            w_frame_err  = 1'b1;
            w_timeout    = 1'b1;
        end
    end

    // Shift register, bit counter, parity capture and idle timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_fall) begin
                r_tmo_cnt <= '0;
                case (r_state)
                    c_ST_IDLE: begin
                        r_bit_cnt <= 3'd0;
                    end
                    c_ST_DATA: begin
                        r_shift   <= {r_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    c_ST_PARITY: begin
                        r_par <= r_dat;
                    end
                    default: begin
                    end
                endcase
            end else if ((r_state == c_ST_IDLE) || w_timeout) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = w_byte_valid;
    assign o_frame_err  = w_frame_err;
    assign o_timeout    = w_timeout;

endmodule
`default_nettype wire

// File: rtl/ps2_keypad.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keypad
// Description : PS/2 keyboard receiver and CHIP-8 keypad decoder. Folds the
//               E0/F0 prefixes into single key events and keeps the 16-key
//               held-key bitmap.
// Ports       : clk        - system clock (25 MHz)
//               reset_n    - asynchronous active-low reset
//               ps2_clk    - PS/2 clock from user_io
//               ps2_data   - PS/2 data from user_io
//               scan_code  - last completed non-prefix byte
//               scan_ext   - E0 prefix preceded scan_code
//               scan_break - F0 prefix preceded scan_code
//               scan_valid - one-cycle strobe for the scan_* outputs
//               keys       - held state of CHIP-8 keys 0x0..0xF
//               frame_err  - one-cycle strobe on parity/stop/timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000,
    parameter int KEY_W       = 16     // must be 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [7:0]       scan_code,
    output logic             scan_ext,
    output logic             scan_break,
    output logic             scan_valid,
    output logic [KEY_W-1:0] keys,
    output logic             frame_err
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid, w_rx_err, w_rx_timeout;
    keymap_t    w_map;

    logic             r_ext_pend, r_brk_pend;
    logic [7:0]       r_scan_code;
    logic             r_scan_ext, r_scan_break, r_scan_valid, r_frame_err;
    logic [KEY_W-1:0] r_keys;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_frame_err  (w_rx_err),
        .o_timeout    (w_rx_timeout)
    );

    assign w_map = chip8_keymap(w_rx_byte);

    // Prefix folding and output registers. A plain frame error keeps the
    // pending prefixes (the next good byte still belongs to them); only a
    // timeout, which means the stream lost sync, discards them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_scan_code  <= 8'h00;
            r_scan_ext   <= 1'b0;
            r_scan_break <= 1'b0;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_keys       <= '0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= w_rx_err;
            if (w_rx_timeout) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_rx_valid) begin
                if (w_rx_byte == c_PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (w_rx_byte == c_PS2_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_scan_code  <= w_rx_byte;
                    r_scan_ext   <= r_ext_pend;
                    r_scan_break <= r_brk_pend;
                    r_scan_valid <= 1'b1;
                    r_ext_pend   <= 1'b0;
                    r_brk_pend   <= 1'b0;
                    // Extended codes share low bytes with keypad keys; skip them.
                    if (w_map.valid && !r_ext_pend) begin
                        r_keys[w_map.idx] <= ~r_brk_pend;
                    end
                end
            end
        end
    end

    assign scan_code  = r_scan_code;
    assign scan_ext   = r_scan_ext;
    assign scan_break = r_scan_break;
    assign scan_valid = r_scan_valid;
    assign keys       = r_keys;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keypad.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_keypad
// Description : Self-checking bench for ps2_keypad. Expected key events and
//               frame errors are queued as frames are sent and compared when
//               the DUT strobes scan_valid or frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keypad;

    localparam int TIMEOUT_CYC = 25000;
    localparam int HALF        = 8;     // PS/2 half period in clk cycles

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  scan_code;
    logic        scan_ext, scan_break, scan_valid, frame_err;
    logic [15:0] keys;

    always #20 clk = ~clk;

    ps2_keypad #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .KEY_W       (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_ext   (scan_ext),
        .scan_break (scan_break),
        .scan_valid (scan_valid),
        .keys       (keys),
        .frame_err  (frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        bit          ext;
        bit          brk;
        logic [15:0] keys;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ref_cyc  = 0;

    logic        m_ext  = 1'b0;
    logic        m_brk  = 1'b0;
    logic [15:0] m_keys = 16'h0000;
    logic [7:0]  key_codes [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                                    8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the prefix layer and keymap.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_ext) begin
                for (int i = 0; i < 16; i++) begin
                    if (key_codes[i] == b) m_keys[i] = ~m_brk;
                end
            end
            e.is_err = 1'b0;
            e.code   = b;
            e.ext    = m_ext;
            e.brk    = m_brk;
            e.keys   = m_keys;
            e.lat    = 4;
            sb.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic push_err(input int lat);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 8'h00;
        e.ext    = 1'b0;
        e.brk    = 1'b0;
        e.keys   = 16'h0000;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        ref_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0);
    endtask

    // Output monitor: one sample per cycle, 1 ns after the active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (scan_valid || frame_err) begin
                check("strobe_overlap", {31'b0, scan_valid & frame_err}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_event", {30'b0, scan_valid, frame_err}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {31'b0, frame_err}, {31'b0, e.is_err});
                    if (!e.is_err) begin
                        check("scan_code", {24'b0, scan_code}, {24'b0, e.code});
                        check("scan_ext", {31'b0, scan_ext}, {31'b0, e.ext});
                        check("scan_break", {31'b0, scan_break}, {31'b0, e.brk});
                        check("keys_at_strobe", {16'b0, keys}, {16'b0, e.keys});
                    end
                    check("latency", cyc - ref_cyc, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check("reset_outputs", {4'b0, scan_code, scan_ext, scan_break, scan_valid, keys, frame_err}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single press / release of W (key 0x5).
        send_good(8'h1D);
        check("keys_press", {16'b0, keys}, 32'h0020);
        send_good(8'hF0);
        send_good(8'h1D);
        check("keys_release", {16'b0, keys}, 32'h0000);

        // Extended code: up arrow, keys unchanged, code held after strobe.
        send_good(8'hE0);
        send_good(8'h75);
        repeat (20) @(negedge clk);
        check("scan_code_held", {24'b0, scan_code}, 32'h75);
        check("keys_ext", {16'b0, keys}, 32'h0000);

        // Bad parity, then the same code good.
        push_err(4);
        send_frame(8'h16, 1'b1);
        check("keys_bad_par", {16'b0, keys}, 32'h0000);
        send_good(8'h16);
        check("keys_good_16", {16'b0, keys}, 32'h0002);

        // A frame error between F0 and the code keeps the break prefix.
        send_good(8'hF0);
        push_err(4);
        send_frame(8'h55, 1'b1);
        send_good(8'h16);
        check("keys_brk_kept", {16'b0, keys}, 32'h0000);

        // Timeout: E0 pending, then start + 4 data bits and silence.
        send_good(8'hE0);
        push_err(TIMEOUT_CYC + 4);
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        send_good(8'h22);
        check("keys_after_tmo", {16'b0, keys}, 32'h0001);

        // Typematic repeat keeps the bit set; add key 0xF.
        send_good(8'h22);
        send_good(8'h2A);
        check("keys_0_and_f", {16'b0, keys}, 32'h8001);

        // Reset in the middle of a frame, with keys held.
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(1'b1);
        @(negedge clk);
        reset_n  = 1'b0;
        ps2_data = 1'b1;
        #1;
        check("reset_async", {4'b0, scan_code, scan_ext, scan_break, scan_valid, keys, frame_err}, 32'd0);
        m_keys = 16'h0000;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("keys_post_reset", {16'b0, keys}, 32'h0000);

        // Fresh frame after reset.
        send_good(8'h24);
        check("keys_fresh", {16'b0, keys}, 32'h0040);

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
